// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared constants for the BRAM arbiter. This covers the FSM
//               state encodings, the owner tags for in-flight reads and the
//               full-word strobe.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RMW_RD = 2'd1;
    localparam logic [1:0] ST_RMW_WR = 2'd2;

    // Owner of the read currently in flight in the BRAM pipeline
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Strobe pattern that writes a whole word without a read-modify-write
    localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester picker for the fetch (I) and data (D) ports.
//               It uses round-robin on ties. DATA_PRIO=1 makes D always win
//               a tie.
// Ports       : clk, rst_n      - clock, async active-low reset
//               en              - grants allowed this cycle
//               req_i, req_d    - requests
//               gnt_i, gnt_d    - one-hot (or zero) grants
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter int DATA_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    // 1 = data port is favoured on the next tie
    logic prio_d_q;
    logic prio_d_d;
    logic w_d_wins_tie;

    assign w_d_wins_tie = (DATA_PRIO != 0) || prio_d_q;

    always_comb begin
        gnt_d    = en && req_d && (!req_i || w_d_wins_tie);
        gnt_i    = en && req_i && !(req_d && w_d_wins_tie);
        prio_d_d = prio_d_q;
        // After a tie the pointer moves to whichever port lost.
        if (en && req_i && req_d) begin
            prio_d_d = gnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_d_q <= 1'b1;
        end else begin
            prio_d_q <= prio_d_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Lets the instruction-fetch port and the load/store port share
//               one single-port word BRAM.
//               - Reads are pipelined, so one read can issue per cycle.
//               - Sub-word stores are done as a read-modify-write.
// Ports       : i_*  - fetch port (req/addr in, ack/rdata/rvalid out)
//               d_*  - data port (req/we/addr/wdata/wstrb in, ack/rdata/rvalid out)
//               m_*  - BRAM side (rd_en/addr/wr_en/wr_data out, rd_data/rd_valid in)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              m_rd_en,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_valid,
    output logic              m_wr_en,
    output logic [DATA_W-1:0] m_wr_data
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              inflight_q;
    logic              inflight_d;
    logic              tag_q;
    logic              tag_d;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_arb_en;
    logic [DATA_W-1:0] w_merged;

    // Grants are suppressed while reset is asserted, so that every output
    // stays low even if requests are present during reset.
    assign w_arb_en = rst_n && (state_q == ST_IDLE);

    rr_arb2 #(
        .DATA_PRIO (DATA_PRIO)
    ) u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_arb_en),
        .req_i (i_req),
        .req_d (d_req),
        .gnt_i (w_gnt_i),
        .gnt_d (w_gnt_d)
    );

    // Byte merge for read-modify-write. The BRAM word read back is combined
    // with the store data, one lane at a time.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_merged[8*k +: 8] = d_wstrb[k] ? d_wdata[8*k +: 8] : m_rd_data[8*k +: 8];
    end

    always_comb begin
        state_d    = state_q;
        inflight_d = 1'b0;      // a read is in flight for exactly one cycle
        tag_d      = tag_q;
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        m_rd_en    = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = '0;
        m_wr_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_i) begin
                    m_rd_en    = 1'b1;
                    m_addr     = i_addr;
                    i_ack      = 1'b1;
                    inflight_d = 1'b1;
                    tag_d      = OWN_I;
                end else if (w_gnt_d) begin
                    m_addr = d_addr;
                    if (!d_we) begin
                        m_rd_en    = 1'b1;
                        d_ack      = 1'b1;
                        inflight_d = 1'b1;
                        tag_d      = OWN_D;
                    end else if (d_wstrb == WSTRB_FULL) begin
                        m_wr_en   = 1'b1;
                        m_wr_data = d_wdata;
                        d_ack     = 1'b1;
                    end else if (d_wstrb == 4'h0) begin
                        d_ack = 1'b1;
                    end else begin
                        // The RMW read leaves inflight clear, so it never raises an rvalid.
                        m_rd_en = 1'b1;
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RMW_RD: begin
                m_addr    = d_addr;
                m_wr_en   = 1'b1;
                m_wr_data = w_merged;
                d_ack     = 1'b1;
                state_d   = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            tag_q      <= OWN_D;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    // Response routing by owner tag
    assign i_rvalid = m_rd_valid && inflight_q && (tag_q == OWN_I);
    assign d_rvalid = m_rd_valid && inflight_q && (tag_q == OWN_D);
    assign i_rdata  = (tag_q == OWN_I) ? m_rd_data : '0;
    assign d_rdata  = (tag_q == OWN_D) ? m_rd_data : '0;

`ifndef SYNTHESIS
    // Requesters must hold their request until it is acknowledged.
    a_i_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (i_req && !i_ack) |=> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_ack) |=> d_req);
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n)
        !(m_rd_en && m_wr_en));
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. It includes a
//               behavioural registered-read BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [12:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [12:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        m_rd_en;
    logic [12:0] m_addr;
    logic [31:0] m_rd_data = '0;
    logic        m_rd_valid = 1'b0;
    logic        m_wr_en;
    logic [31:0] m_wr_data;

    int passed = 0;
    int total  = 0;
    int overlap = 0;

    logic [31:0] mem [0:2047];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(13), .DATA_W(32), .DATA_PRIO(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .i_rvalid   (i_rvalid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .d_rvalid   (d_rvalid),
        .m_rd_en    (m_rd_en),
        .m_addr     (m_addr),
        .m_rd_data  (m_rd_data),
        .m_rd_valid (m_rd_valid),
        .m_wr_en    (m_wr_en),
        .m_wr_data  (m_wr_data)
    );

    // BRAM model: registered read, one cycle of latency, whole-word write
    always @(posedge clk) begin
        if (m_wr_en) mem[m_addr[12:2]] <= m_wr_data;
        if (m_rd_en) m_rd_data <= mem[m_addr[12:2]];
        m_rd_valid <= m_rd_en;
    end

    always @(negedge clk) begin
        if (m_rd_en && m_wr_en) overlap++;
    end

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({i_ack, d_ack, i_rvalid, d_rvalid, m_rd_en, m_wr_en} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {i_ack, d_ack, i_rvalid, d_rvalid, m_rd_en, m_wr_en});
        else passed++;
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b0)
            $display("FAIL reset_idle: got %b want 0000", {i_ack, d_ack, m_rd_en, m_wr_en});
        else passed++;
    endtask

    // Fetch of 0x010 held for 3 cycles
    task automatic test_fetch();
        logic [3:0] exp;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            i_req = (c < 3); i_addr = 13'h010;
            @(negedge clk);
            exp = {(c < 3), 1'b0, (c < 3), 1'b0};
            total++;
            if ({i_ack, d_ack, m_rd_en, m_wr_en} !== exp)
                $display("FAIL fetch_ack c%0d: got %b want %b", c, {i_ack, d_ack, m_rd_en, m_wr_en}, exp);
            else passed++;
            total++;
            if ({i_rvalid, d_rvalid} !== {(c >= 1), 1'b0})
                $display("FAIL fetch_rvalid c%0d: got %b want %b", c, {i_rvalid, d_rvalid}, {(c >= 1), 1'b0});
            else passed++;
            if (c >= 1) begin
                total++;
                if (i_rdata !== 32'hCAFE0004)
                    $display("FAIL fetch_rdata c%0d: got %h want cafe0004", c, i_rdata);
                else passed++;
            end
        end
    endtask

    // Fetch and data load tie; round-robin gives D,I,D,I
    task automatic test_tie();
        logic exp_i, exp_d, pv_i, pv_d;
        d_we = 1'b0; d_addr = 13'h020; i_addr = 13'h030;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            i_req = (c < 4); d_req = (c < 3);
            @(negedge clk);
            exp_d = (c < 4) && (c % 2 == 0);
            exp_i = (c < 4) && (c % 2 == 1);
            total++;
            if ({i_ack, d_ack} !== {exp_i, exp_d})
                $display("FAIL tie_grant c%0d: got %b want %b", c, {i_ack, d_ack}, {exp_i, exp_d});
            else passed++;
            if (c >= 1) begin
                pv_d = ((c - 1) % 2 == 0);
                pv_i = ((c - 1) % 2 == 1);
                total++;
                if ({i_rvalid, d_rvalid} !== {pv_i, pv_d})
                    $display("FAIL tie_rvalid c%0d: got %b want %b", c, {i_rvalid, d_rvalid}, {pv_i, pv_d});
                else passed++;
                total++;
                if (pv_d ? (d_rdata !== 32'hD0D00008) : (i_rdata !== 32'h1111000C))
                    $display("FAIL tie_rdata c%0d: got i=%h d=%h want %h", c, i_rdata, d_rdata,
                             pv_d ? 32'hD0D00008 : 32'h1111000C);
                else passed++;
            end
        end
    endtask

    // Byte store to mem[2] via RMW; the fetch request arriving meanwhile stalls
    task automatic test_byte_store();
        logic [3:0] exp [5];
        exp = '{4'b0010, 4'b0101, 4'b0000, 4'b1010, 4'b0000};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            d_req = (c < 2); d_we = 1'b1; d_addr = 13'h008;
            d_wdata = 32'h000000AA; d_wstrb = 4'b0001;
            i_req = (c >= 1) && (c < 4); i_addr = 13'h010;
            @(negedge clk);
            total++;
            if ({i_ack, d_ack, m_rd_en, m_wr_en} !== exp[c])
                $display("FAIL rmw_ctrl c%0d: got %b want %b", c, {i_ack, d_ack, m_rd_en, m_wr_en}, exp[c]);
            else passed++;
            if (c == 1) begin
                total++;
                if (m_wr_data !== 32'h112233AA || d_rvalid !== 1'b0)
                    $display("FAIL rmw_merge: got %h rv=%b want 112233aa rv=0", m_wr_data, d_rvalid);
                else passed++;
            end
        end
        total++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFE0004)
            $display("FAIL rmw_fetch_after: got rv=%b %h want rv=1 cafe0004", i_rvalid, i_rdata);
        else passed++;
        total++;
        if (mem[2] !== 32'h112233AA)
            $display("FAIL rmw_mem: got %h want 112233aa", mem[2]);
        else passed++;
    endtask

    // Full store and then a load of the same word, back-to-back
    task automatic test_back_to_back();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h040; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b0101 || m_wr_data !== 32'hDEADBEEF)
            $display("FAIL b2b_store: got %b %h want 0101 deadbeef", {i_ack, d_ack, m_rd_en, m_wr_en}, m_wr_data);
        else passed++;
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b0110)
            $display("FAIL b2b_load: got %b want 0110", {i_ack, d_ack, m_rd_en, m_wr_en});
        else passed++;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF)
            $display("FAIL b2b_rdata: got rv=%b %h want rv=1 deadbeef", d_rvalid, d_rdata);
        else passed++;
        total++;
        if (overlap !== 0)
            $display("FAIL b2b_overlap: got %0d want 0", overlap);
        else passed++;
    endtask

    // Store with an all-zero strobe: acknowledged at once, no BRAM access
    task automatic test_zero_strobe();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h044; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'h0;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b0100)
            $display("FAIL zero_strb_ack: got %b want 0100", {i_ack, d_ack, m_rd_en, m_wr_en});
        else passed++;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({d_rvalid, m_wr_en, m_rd_en} !== 3'b000 || mem[17] !== 32'h0BADF00D)
            $display("FAIL zero_strb_after: got %b mem=%h want 000 0badf00d", {d_rvalid, m_wr_en, m_rd_en}, mem[17]);
        else passed++;
    endtask

    // Reset asserted in RMW_RD abandons the store
    task automatic test_reset_mid_rmw();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h00C; d_wdata = 32'h00009900; d_wstrb = 4'b0010;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b0010)
            $display("FAIL rst_rmw_issue: got %b want 0010", {i_ack, d_ack, m_rd_en, m_wr_en});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en, i_rvalid, d_rvalid} !== 6'b0)
            $display("FAIL rst_rmw_outputs: got %b want 000000",
                     {i_ack, d_ack, m_rd_en, m_wr_en, i_rvalid, d_rvalid});
        else passed++;
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (mem[3] !== 32'h55667788)
            $display("FAIL rst_rmw_mem: got %h want 55667788", mem[3]);
        else passed++;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 13'h00C;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_rd_en, m_wr_en} !== 4'b1010)
            $display("FAIL rst_rmw_first_ack: got %b want 1010", {i_ack, d_ack, m_rd_en, m_wr_en});
        else passed++;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        total++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h55667788)
            $display("FAIL rst_rmw_first_data: got rv=%b %h want rv=1 55667788", i_rvalid, i_rdata);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[2]  = 32'h11223344;
        mem[3]  = 32'h55667788;
        mem[4]  = 32'hCAFE0004;
        mem[8]  = 32'hD0D00008;
        mem[12] = 32'h1111000C;
        mem[16] = 32'h00000000;
        mem[17] = 32'h0BADF00D;

        test_reset();
        test_fetch();
        test_tie();
        test_byte_store();
        test_back_to_back();
        test_zero_strobe();
        test_reset_mid_rmw();

        total++;
        if (overlap !== 0)
            $display("FAIL rd_wr_overlap: got %0d want 0", overlap);
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
